// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared FPGA configuration package for the CCFF bitstream loader.
// Contents:
//   CCFF_BYTE_W  - bitstream byte width
//   CCFF_BCNT_W  - width of the serializer remaining-bit counter
//   ccff_state_e - loader FSM state encoding
//   ccff_nbytes  - number of bytes needed to fill a chain of a given length
package ccff_bitstream_loader_pkg;

  localparam int unsigned CCFF_BYTE_W = 8;
  localparam int unsigned CCFF_BCNT_W = 4;

  typedef enum logic [1:0] {
    CCFF_IDLE = 2'd0,
    CCFF_LOAD = 2'd1,
    CCFF_DONE = 2'd2
  } ccff_state_e;

  function automatic int unsigned ccff_nbytes(input int unsigned chain_len);
    return (chain_len + CCFF_BYTE_W - 1) / CCFF_BYTE_W;
  endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// Byte-to-bit serializer: one holding register feeding one shift register.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   flush_i        - synchronously drops holding and shift contents
//   in_data_i      - byte input (LSB leaves first)
//   in_valid_i     - byte offered; accepted when in_ready_o is 1
//   in_ready_o     - holding register is empty
//   bit_o          - current bit at the serial output
//   bit_valid_o    - bit_o carries a real bit
//   bit_take_i     - consumer takes bit_o this cycle (only when bit_valid_o)
module ccff_byte_serializer
  import ccff_bitstream_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [CCFF_BYTE_W-1:0] in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   bit_o,
  output logic                   bit_valid_o,
  input  logic                   bit_take_i
);

  logic [CCFF_BYTE_W-1:0] hold_q;
  logic                   hold_v_q;
  logic [CCFF_BYTE_W-1:0] sh_q;
  logic [CCFF_BCNT_W-1:0] cnt_q;
  logic                   sh_has;

  assign sh_has      = (cnt_q != '0);
  assign in_ready_o  = ~hold_v_q;
  // With the shift register empty, the holding register's LSB is presented
  // directly so the first bit of a load is available one cycle after the
  // byte lands; the byte then moves to the shift register minus that bit.
  assign bit_valid_o = sh_has | hold_v_q;
  assign bit_o       = sh_has ? sh_q[0] : hold_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else begin
      if (!sh_has) begin
        if (hold_v_q) begin
          hold_v_q <= 1'b0;
          if (bit_take_i) begin
            sh_q  <= hold_q >> 1;
            cnt_q <= CCFF_BCNT_W'(CCFF_BYTE_W - 1);
          end else begin
            sh_q  <= hold_q;
            cnt_q <= CCFF_BCNT_W'(CCFF_BYTE_W);
          end
        end
      end else if (bit_take_i) begin
        // Last bit leaving: refill from the holding register in the same
        // cycle so consecutive bytes shift without a bubble.
        if ((cnt_q == CCFF_BCNT_W'(1)) && hold_v_q) begin
          sh_q     <= hold_q;
          cnt_q    <= CCFF_BCNT_W'(CCFF_BYTE_W);
          hold_v_q <= 1'b0;
        end else begin
          sh_q  <= sh_q >> 1;
          cnt_q <= cnt_q - CCFF_BCNT_W'(1);
        end
      end
      // Accept only into an empty holding register; never collides with the
      // hold_v_q clears above, which require hold_v_q=1.
      if (in_valid_i && !hold_v_q) begin
        hold_q   <= in_data_i;
        hold_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a serial configuration-flop chain of CHAIN_LEN flops from a byte
// stream, exactly CHAIN_LEN shift pulses per load.
// Ports:
//   prog_clk, prog_reset - clock, synchronous active-high reset
//   start                - one-cycle load request (ignored unless idle)
//   abort                - cancels a load in progress
//   s_data/s_valid/s_ready - byte stream handshake, LSB shifted first
//   ccff_head            - registered serial bit into the chain head
//   ccff_shift_en        - registered chain shift enable
//   busy                 - load in progress
//   done                 - one-cycle pulse after the final shift
module ccff_bitstream_loader
  import ccff_bitstream_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CCFF_BYTE_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   ccff_head,
  output logic                   ccff_shift_en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NBYTES  = ccff_nbytes(CHAIN_LEN);
  localparam int unsigned BIT_CW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BYTE_CW = $clog2(NBYTES + 1);
  localparam logic [BIT_CW-1:0]  CHAIN_LEN_C = BIT_CW'(CHAIN_LEN);
  localparam logic [BYTE_CW-1:0] NBYTES_C    = BYTE_CW'(NBYTES);

  ccff_state_e          state_q;
  logic [BIT_CW-1:0]    bit_cnt_q;
  logic [BYTE_CW-1:0]   byte_cnt_q;
  logic                 head_q;
  logic                 shift_en_q;
  logic                 busy_q;
  logic                 done_q;

  logic in_load;
  logic ser_in_ready;
  logic ser_bit;
  logic ser_bit_valid;
  logic byte_fire;
  logic take;
  logic ser_flush;

  assign in_load   = (state_q == CCFF_LOAD);
  assign s_ready   = in_load && ser_in_ready && (byte_cnt_q < NBYTES_C);
  assign byte_fire = s_valid && s_ready;
  assign take      = in_load && !abort && ser_bit_valid && (bit_cnt_q < CHAIN_LEN_C);
  // Leftover bits of the final byte, and everything on abort, are dropped.
  assign ser_flush = !in_load || abort;

  ccff_byte_serializer u_ser (
    .clk_i       (prog_clk),
    .rst_i       (prog_reset),
    .flush_i     (ser_flush),
    .in_data_i   (s_data),
    .in_valid_i  (byte_fire),
    .in_ready_o  (ser_in_ready),
    .bit_o       (ser_bit),
    .bit_valid_o (ser_bit_valid),
    .bit_take_i  (take)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= CCFF_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        CCFF_IDLE: begin
          if (start) begin
            state_q    <= CCFF_LOAD;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        CCFF_LOAD: begin
          if (abort) begin
            state_q <= CCFF_IDLE;
            busy_q  <= 1'b0;
          end else if (bit_cnt_q == CHAIN_LEN_C) begin
            // Count reached during the cycle the last shift is visible, so
            // done lands on the following cycle.
            state_q <= CCFF_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            if (take) begin
              head_q     <= ser_bit;
              shift_en_q <= 1'b1;
              bit_cnt_q  <= bit_cnt_q + BIT_CW'(1);
            end
            if (byte_fire) begin
              byte_cnt_q <= byte_cnt_q + BYTE_CW'(1);
            end
          end
        end
        CCFF_DONE: begin
          state_q <= CCFF_IDLE;
        end
        default: begin
          state_q <= CCFF_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: a 16-flop instance (A) and a
// 12-flop instance (B). Stimulus pushes expected chain bits and expected
// shift totals at done; per-instance monitors pop and compare.
module tb_ccff_bitstream_loader;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_start, a_abort, a_svalid;
  logic [7:0] a_sdata;
  logic       a_s_ready, a_head, a_shift_en, a_busy, a_done;
  logic       b_reset, b_start, b_abort, b_svalid;
  logic [7:0] b_sdata;
  logic       b_s_ready, b_head, b_shift_en, b_busy, b_done;

  ccff_bitstream_loader #(.CHAIN_LEN(16)) u_dut_a (
    .prog_clk      (clk),
    .prog_reset    (a_reset),
    .start         (a_start),
    .abort         (a_abort),
    .s_data        (a_sdata),
    .s_valid       (a_svalid),
    .s_ready       (a_s_ready),
    .ccff_head     (a_head),
    .ccff_shift_en (a_shift_en),
    .busy          (a_busy),
    .done          (a_done)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12)) u_dut_b (
    .prog_clk      (clk),
    .prog_reset    (b_reset),
    .start         (b_start),
    .abort         (b_abort),
    .s_data        (b_sdata),
    .s_valid       (b_svalid),
    .s_ready       (b_s_ready),
    .ccff_head     (b_head),
    .ccff_shift_en (b_shift_en),
    .busy          (b_busy),
    .done          (b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic qa[$];
  logic qb[$];
  int   qad[$];
  int   qbd[$];
  int   a_shifts = 0;
  int   b_shifts = 0;
  int   a_exp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) qa.push_back(b[i]);
  endtask

  task automatic push_b(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) qb.push_back(b[i]);
  endtask

  // Monitor A
  initial begin
    logic prev_se, prev_head;
    prev_se = 1'b0;
    prev_head = 1'b0;
    forever begin
      @(negedge clk);
      if (a_shift_en === 1'b1) begin
        check("A shift expected", qa.size() != 0, 1);
        if (qa.size() != 0) check("A head bit", a_head, qa.pop_front());
        a_shifts++;
      end else if (a_busy === 1'b1) begin
        check("A head hold", a_head, prev_head);
      end
      if (a_done === 1'b1) begin
        check("A done expected", qad.size() != 0, 1);
        if (qad.size() != 0) check("A shifts at done", a_shifts, qad.pop_front());
        check("A done after last shift", prev_se, 1);
      end
      prev_se = a_shift_en;
      prev_head = a_head;
    end
  end

  // Monitor B
  initial begin
    logic prev_se, prev_head;
    prev_se = 1'b0;
    prev_head = 1'b0;
    forever begin
      @(negedge clk);
      if (b_shift_en === 1'b1) begin
        check("B shift expected", qb.size() != 0, 1);
        if (qb.size() != 0) check("B head bit", b_head, qb.pop_front());
        b_shifts++;
      end else if (b_busy === 1'b1) begin
        check("B head hold", b_head, prev_head);
      end
      if (b_done === 1'b1) begin
        check("B done expected", qbd.size() != 0, 1);
        if (qbd.size() != 0) check("B shifts at done", b_shifts, qbd.pop_front());
        check("B done after last shift", prev_se, 1);
      end
      prev_se = b_shift_en;
      prev_head = b_head;
    end
  end

  task automatic a_send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    a_sdata = b;
    a_svalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (a_s_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("A handshake", ok, 1);
  endtask

  task automatic b_send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    b_sdata = b;
    b_svalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (b_s_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("B handshake", ok, 1);
  endtask

  // Bytes 0xA5,0x3C with s_valid held high. stop_at=0: full load;
  // otherwise after stop_at shifts apply abort (action 0) or reset (action 1).
  // poke issues start pulses mid-load, which must be ignored.
  task automatic a_load(input int stop_at, input int action, input bit poke);
    int run;
    if (stop_at == 0) begin
      push_a(8'hA5, 8);
      push_a(8'h3C, 8);
      a_exp += 16;
      qad.push_back(a_exp);
    end else begin
      push_a(8'hA5, (stop_at > 8) ? 8 : stop_at);
      if (stop_at > 8) push_a(8'h3C, stop_at - 8);
      a_exp += stop_at;
    end
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("A busy after start", a_busy, 1);
    check("A s_ready first byte", a_s_ready, 1);
    a_sdata = 8'hA5;
    a_svalid = 1'b1;
    @(negedge clk);
    check("A s_ready hold full", a_s_ready, 0);
    check("A no shift before latency", a_shift_en, 0);
    a_sdata = 8'h3C;
    @(negedge clk);
    check("A s_ready second byte", a_s_ready, 1);
    check("A first shift latency", a_shift_en, 1);
    run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_svalid = 1'b0;
        check("A s_ready after last byte", a_s_ready, 0);
      end
      a_start = poke && (i == 3 || i == 8);
      if (!a_shift_en) break;
      run++;
      if (stop_at != 0 && run == stop_at) break;
    end
    a_start = 1'b0;
    if (stop_at == 0) begin
      check("A consecutive shifts", run, 16);
      check("A done pulse", a_done, 1);
      check("A busy in done", a_busy, 0);
      @(negedge clk);
      check("A done one cycle", a_done, 0);
      check("A busy after done", a_busy, 0);
    end else begin
      check("A shifts before cut", run, stop_at);
      if (action == 0) a_abort = 1'b1;
      else a_reset = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      a_reset = 1'b0;
      check("A busy after cut", a_busy, 0);
      check("A shift_en after cut", a_shift_en, 0);
      check("A s_ready after cut", a_s_ready, 0);
      check("A done after cut", a_done, 0);
      if (action == 1) check("A head after reset", a_head, 0);
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    a_reset = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_svalid = 1'b0; a_sdata = '0;
    b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_svalid = 1'b0; b_sdata = '0;
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    check("A reset s_ready", a_s_ready, 0);
    check("A reset head", a_head, 0);
    check("A reset shift_en", a_shift_en, 0);
    check("A reset busy", a_busy, 0);
    check("A reset done", a_done, 0);
    check("B reset busy", b_busy, 0);
    check("B reset s_ready", b_s_ready, 0);

    // Gapless 16-bit load
    a_load(0, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Underrun: 5-cycle gap between bytes
    push_a(8'hA5, 8);
    push_a(8'h3C, 8);
    a_exp += 16;
    qad.push_back(a_exp);
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_send(8'hA5);
    a_svalid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_shift_en) cnt++;
      if (cnt == 8) break;
    end
    check("A first byte shifts", cnt, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("A underrun shift_en", a_shift_en, 0);
    end
    a_send(8'h3C);
    a_svalid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_done) break;
    end
    check("A gap load done", a_done, 1);
    repeat (3) @(negedge clk);

    // Abort after 5 shifts, then a full reload with ignored start pulses
    a_load(5, 0, 1'b0);
    a_load(0, 0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset after 9 shifts with an ignored mid-load start, then reload
    a_load(9, 1, 1'b1);
    a_load(0, 0, 1'b0);

    // CHAIN_LEN=12: final byte's upper nibble discarded
    push_b(8'hFF, 8);
    push_b(8'h0F, 4);
    qbd.push_back(12);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_send(8'hFF);
    b_send(8'h0F);
    check("B s_ready after 2nd byte", b_s_ready, 0);
    b_sdata = 8'hAA;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_done) break;
      check("B s_ready stays low", b_s_ready, 0);
    end
    check("B load done", b_done, 1);
    b_svalid = 1'b0;
    repeat (6) @(negedge clk);

    check("A leftover bits", qa.size(), 0);
    check("A leftover dones", qad.size(), 0);
    check("A total shifts", a_shifts, a_exp);
    check("B leftover bits", qb.size(), 0);
    check("B leftover dones", qbd.size(), 0);
    check("B total shifts", b_shifts, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of configuration flops in the downstream chain; SHALL be >= 1.
REQ-002 Parameter NBYTES, default ceil(CHAIN_LEN/8): number of input bytes consumed per load (derived, not overridden).
REQ-003 prog_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 prog_reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; ignored while busy.
REQ-006 abort  input  1  cancels an in-progress load.
REQ-007 s_data  input  8  bitstream byte, LSB shifted first.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 ccff_head  output  1  serial bit driven into the head of the configuration chain.
REQ-011 ccff_shift_en  output  1  enable for the external chain clock gate; the chain captures ccff_head at the end of every cycle in which this is 1.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  one-cycle pulse when the full chain has been loaded.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, DONE.
REQ-015 IDLE -> LOAD on the cycle after start=1; bit and byte counters SHALL clear on that transition.
REQ-016 Byte transfer occurs when s_valid=1 and s_ready=1; s_data SHALL NOT be sampled otherwise.
REQ-017 s_ready = 1 only in LOAD, while the holding register is empty and fewer than NBYTES bytes have been accepted.
REQ-018 Datapath: one 8-bit holding register plus one 8-bit shift register with a 4-bit remaining-bit count; holding register moves to the shift register when the shift register is empty or delivers its last bit in that cycle.
REQ-019 With s_valid held high, shifting SHALL be gapless: one bit per cycle, no bubble between bytes.
REQ-020 ccff_head and ccff_shift_en SHALL be registered; first ccff_shift_en=1 occurs two cycles after the first byte transfer.
REQ-021 When no bit is available (input underrun), ccff_shift_en SHALL be 0 and ccff_head SHALL hold its value; the load resumes without loss.
REQ-022 Exactly CHAIN_LEN cycles with ccff_shift_en=1 SHALL occur per load; bits of the final byte beyond CHAIN_LEN SHALL be discarded, never shifted.
REQ-023 Bit counter width SHALL be clog2(CHAIN_LEN+1); no wrap-around inside a load.
REQ-024 After the cycle carrying the CHAIN_LEN-th shift, the FSM SHALL enter DONE for one cycle (done=1, busy=0), then IDLE.
REQ-025 busy = 1 in LOAD only.
REQ-026 abort=1 in LOAD -> IDLE next cycle; ccff_shift_en=0 from that cycle on; holding/shift contents dropped; done not asserted.
REQ-027 abort has priority over the final shift and over start in the same cycle; abort in IDLE/DONE has no effect.
REQ-028 start in LOAD or DONE SHALL be ignored (no restart, no counter clear).

Reset
REQ-029 prog_reset SHALL force the state to IDLE and set s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, all counters to 0, and the holding register to empty.
REQ-030 prog_reset asserted mid-load SHALL take effect at the next edge, overriding all other inputs, with no further shift pulse.

Structure
REQ-031 FSM state encoding and the byte width constant (8) SHALL reside in the shared FPGA configuration package.
REQ-032 The 8-bit holding/shift pair SHALL be a sub-module ccff_byte_serializer (byte in with valid/ready, bit out with valid); the FSM and counters remain in the top module.

Verification
REQ-033 CHAIN_LEN=16, start, bytes 0xA5,0x3C with s_valid held high -> 16 consecutive shift_en cycles, ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, done pulse the cycle after the last shift.
REQ-034 CHAIN_LEN=12, bytes 0xFF,0x0F -> exactly 12 shifts (eight 1s, four 1s), upper nibble of 0x0F never driven, s_ready=0 after 2nd byte.
REQ-035 CHAIN_LEN=16, s_valid dropped 5 cycles between bytes -> shift_en low for the gap, ccff_head stable, chain contents identical to REQ-033.
REQ-036 abort after 5 shifts -> busy=0 next cycle, no further shift_en, no done; a following start reloads a full 16 bits correctly.
REQ-037 prog_reset after 9 shifts -> all outputs at reset values next cycle; start while busy -> no effect on counters or head sequence.
